l_io_port: RTL and testbench
============================

// Module: l_io_port
// PURPOSE
// - Peripheral at the far end of the CPU logical sector's I/O lines. Accepts each
//   word the CPU writes on outputLine/outputLineWrite, queues it in a small FIFO, and
//   serialises it as two 8N1 UART frames on txd.
// - Supplies inputLine to the CPU from a synchronised, registered copy of the board
//   switch inputs swIn. Sits beside the CPU core in the FPGA top level.
// PARAMETERS
// - CLKS_PER_BIT  434  clock cycles per serial bit (50 MHz / 115200 baud); minimum 2
// - FIFO_DEPTH    4    TX FIFO depth in 16-bit words; must be a power of 2, >= 2
// PORTS
// - clk              in   1   system clock; all state updates on its rising edge
// - reset            in   1   synchronous, active-high reset
// - outputLine       in   16  word written by the CPU
// - outputLineWrite  in   1   write strobe; each cycle it is high pushes one word
// - inputLine        out  16  synchronised switch value returned to the CPU
// - swIn             in   16  asynchronous board switch inputs
// - txd              out  1   UART serial output, idle high
// - txBusy           out  1   high while FIFO is non-empty or a frame is in flight
// - fifoFull         out  1   high when FIFO holds FIFO_DEPTH words
// - overflow         out  1   sticky flag: a write was dropped because FIFO was full
// BEHAVIOUR
// - Reset values: txd=1, inputLine=0, txBusy=0, fifoFull=0, overflow=0. FIFO emptied,
//   all counters zero, FSM=IDLE. Reset mid-frame aborts the frame; txd=1 on the next edge.
// - Push: on an edge with outputLineWrite=1 and count<FIFO_DEPTH, the word is stored.
//   Fullness uses the count before the edge. A push while full is dropped and sets
//   overflow, even if a pop occurs on the same edge. overflow is cleared only by reset.
// - Push and pop on the same edge (FIFO not full): both take effect; count is unchanged.
// - FSM states: IDLE, START, DATA, STOP. A 1-bit byteSel selects the high byte (0) or
//   the low byte (1).
//   - IDLE: if count!=0 -> pop head word, byteSel=0, load high byte, txd<=0, go to START.
//     Otherwise txd=1.
//   - START: hold txd=0 for CLKS_PER_BIT cycles, then go to DATA with bitIdx=0.
//   - DATA: txd=byte[bitIdx], sent LSB first. Each bit lasts CLKS_PER_BIT cycles.
//     After bit 7, go to STOP.
//   - STOP: txd=1 for CLKS_PER_BIT cycles. Then:
//     - if byteSel=0: byteSel=1, load low byte, txd<=0, go to START (no idle gap);
//     - else go to IDLE.
// - Latency: a word pushed on edge E into an empty, idle port drives txd low on edge E+1.
//   A word occupies exactly 20*CLKS_PER_BIT cycles on txd. Back-to-back words are
//   separated by exactly 1 idle-high cycle, the IDLE pop cycle.
// - Counters: the bit-timing counter counts 0..CLKS_PER_BIT-1 and wraps. The FIFO
//   read/write pointers wrap modulo FIFO_DEPTH. count is clog2(FIFO_DEPTH)+1 bits wide.
// - txBusy = (count!=0) | (FSM!=IDLE). fifoFull = (count==FIFO_DEPTH). Both are
//   combinational from registered state.
// - inputLine: swIn passes through a 2-flop synchroniser and then an output register.
//   A swIn change appears on inputLine 3 edges later.
// CONFIGURATION
// - IO_PARITY_EN defined: a PARITY state is inserted between DATA and STOP. It drives
//   even parity (^byte) for CLKS_PER_BIT cycles. Frames are 8E1, and a word takes
//   22*CLKS_PER_BIT cycles.
// - IO_PARITY_EN undefined: 8N1 framing as above. No parity state or logic is present.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
// - Reset -> txd=1, inputLine=0, txBusy=0, fifoFull=0, overflow=0. Hold for 10 cycles;
//   outputs stay unchanged.
// - Single write 16'hA55A -> txd low 1 cycle later. Decode bytes 8'hA5 then 8'h5A.
//   Frame ends 80 cycles after txd falls; txBusy then drops.
// - Six consecutive write cycles of 1..6 while idle -> words 1..5 transmitted in order
//   (one is popped immediately, freeing a slot). Word 6 is dropped and overflow=1 stays
//   set. Exactly 1 idle cycle appears between words.
// - Assert reset during bit 3 of the first byte of 16'h1234 -> txd=1 on the next edge,
//   FIFO empty. The next write of 16'h00FF is sent cleanly.
// - swIn=16'hBEEF -> inputLine=16'hBEEF after exactly 3 edges. Earlier it holds the
//   prior value.
// - With IO_PARITY_EN, write 16'h0301 -> the parity bit is 0 for 8'h03 and 1 for 8'h01.
//   The word takes 88 cycles.

Source files
------------

// File: rtl/l_io_port.sv
// l_io_port
//   CPU-side I/O peripheral. Words written by the CPU are queued in a small TX FIFO
//   and sent on txd as two UART frames each, high byte first, LSB first within a
//   byte. The board switches are synchronised and returned to the CPU on inputLine.
//
//   Build option: define IO_PARITY_EN to insert an even-parity bit into each frame
//   (8E1). When it is undefined, frames are 8N1.
//
// Ports
//   clk             system clock, rising edge
//   reset           synchronous, active-high reset
//   outputLine      word written by the CPU
//   outputLineWrite write strobe; one word is pushed per high cycle
//   inputLine       synchronised switch value returned to the CPU
//   swIn            asynchronous board switch inputs
//   txd             UART serial output, idle high
//   txBusy          FIFO non-empty or a frame in flight
//   fifoFull        FIFO holds FIFO_DEPTH words
//   overflow        sticky: a write was dropped because the FIFO was full
module l_io_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] outputLine,
  input  logic        outputLineWrite,
  output logic [15:0] inputLine,
  input  logic [15:0] swIn,
  output logic        txd,
  output logic        txBusy,
  output logic        fifoFull,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef IO_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;

  state_t        state;
  logic          byteSel;   // 0: high byte in flight, 1: low byte
  logic [15:0]   curWord;
  logic [2:0]    bitIdx;
  logic [CW-1:0] clkCnt;

  logic [15:0]   swMeta, swSync;

  logic [7:0]    curByte;
  logic          push, pop, bitDone;

  assign fifoFull = (count == DEPTH_CNT);
  assign txBusy   = (count != '0) || (state != IDLE);
  // Fullness is judged on the count before the edge, so a simultaneous pop does
  // not make room for a write that arrives while full.
  assign push     = outputLineWrite && !fifoFull;
  assign pop      = (state == IDLE) && (count != '0);
  assign curByte  = byteSel ? curWord[7:0] : curWord[15:8];
  assign bitDone  = (clkCnt == CNT_LAST);

  // NOTE: the storage array has no reset; only pointers and count define which
  // entries are valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= outputLine;
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (outputLineWrite && fifoFull) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serialiser. txd is registered and always holds the level of the current bit;
  // each transition loads the level of the next bit so it appears on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      byteSel <= 1'b0;
      curWord <= '0;
      bitIdx  <= '0;
      clkCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          clkCnt <= '0;
          if (pop) begin
            curWord <= mem[rdPtr];
            byteSel <= 1'b0;
            txd     <= 1'b0;
            state   <= START;
          end else begin
            txd <= 1'b1;
          end
        end
        START: begin
          if (bitDone) begin
            clkCnt <= '0;
            bitIdx <= '0;
            txd    <= curByte[0];
            state  <= DATA;
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        DATA: begin
          if (bitDone) begin
            clkCnt <= '0;
            if (bitIdx == 3'd7) begin
`ifdef IO_PARITY_EN
              txd   <= ^curByte;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bitIdx <= bitIdx + 3'd1;
              txd    <= curByte[bitIdx + 3'd1];
            end
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
`ifdef IO_PARITY_EN
        PARITY: begin
          if (bitDone) begin
            clkCnt <= '0;
            txd    <= 1'b1;
            state  <= STOP;
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bitDone) begin
            clkCnt <= '0;
            if (!byteSel) begin
              // Low byte follows immediately with no idle gap.
              byteSel <= 1'b1;
              txd     <= 1'b0;
              state   <= START;
            end else begin
              txd   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Two-flop synchroniser followed by the output register: 3 edges of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      swMeta    <= '0;
      swSync    <= '0;
      inputLine <= '0;
    end else begin
      swMeta    <= swIn;
      swSync    <= swMeta;
      inputLine <= swSync;
    end
  end

endmodule

// File: tb/tb_l_io_port.sv
// Testbench for l_io_port with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same
// point, so each sample reflects the edge just taken.
module tb_l_io_port;

  localparam int CPB = 4;
`ifdef IO_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] outputLine;
  logic        outputLineWrite;
  logic [15:0] inputLine;
  logic [15:0] swIn;
  logic        txd;
  logic        txBusy;
  logic        fifoFull;
  logic        overflow;

  int nVec  = 0;
  int nMiss = 0;

  l_io_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .outputLine     (outputLine),
    .outputLineWrite(outputLineWrite),
    .inputLine      (inputLine),
    .swIn           (swIn),
    .txd            (txd),
    .txBusy         (txBusy),
    .fifoFull       (fifoFull),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        wr;
    logic [15:0] word;
    logic [15:0] sw;
    logic [15:0] expIn;
    logic        expTxd;
    logic        expBusy;
    logic        expFull;
    logic        expOvf;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goTo(inout int pos, input int target);
    while (pos < target) begin
      tick();
      pos++;
    end
  endtask

  // Decode one word whose start bit fell on the edge at position 0; the caller is
  // currently startPos edges past that point. Ends at position 2*FRAME.
  task automatic recvWord(input int startPos, input string name, output logic [15:0] w);
    int pos;
    logic [7:0] b;
    pos = startPos;
    w = '0;
    for (int j = 0; j < 2; j++) begin
      int base;
      base = j * FRAME;
      if (pos <= base + 2) begin
        goTo(pos, base + 2);
        check({name, " start bit"}, 16'(txd), 16'd0);
      end
      for (int k = 0; k < 8; k++) begin
        goTo(pos, base + 6 + 4 * k);
        b[k] = txd;
      end
`ifdef IO_PARITY_EN
      goTo(pos, base + 38);
      check({name, " parity bit"}, 16'(txd), 16'(^b));
`endif
      goTo(pos, base + FRAME - 2);
      check({name, " stop bit"}, 16'(txd), 16'd1);
      if (j == 0) w[15:8] = b;
      else        w[7:0]  = b;
    end
    goTo(pos, 2 * FRAME);
  endtask

  logic [15:0] got;

  initial begin
    reset = 1'b1;
    outputLine = '0;
    outputLineWrite = 1'b0;
    swIn = '0;

    // Reset held for 10 cycles: outputs remain at reset values throughout.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset txd", 16'(txd), 16'd1);
      check("reset inputLine", inputLine, 16'h0000);
      check("reset txBusy", 16'(txBusy), 16'd0);
      check("reset fifoFull", 16'(fifoFull), 16'd0);
      check("reset overflow", 16'(overflow), 16'd0);
    end

    //           rst   wr    word      sw        expIn     txd   busy  full  ovf
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'h1234, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 16'h1234, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0};
    // Write A55A: stored on this edge, txd falls on the following one.
    tbl[8] = '{1'b0, 1'b1, 16'hA55A, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      reset = tbl[i].rst;
      outputLineWrite = tbl[i].wr;
      outputLine = tbl[i].word;
      swIn = tbl[i].sw;
      tick();
      check($sformatf("vec%0d inputLine", i), inputLine, tbl[i].expIn);
      check($sformatf("vec%0d txd", i), 16'(txd), 16'(tbl[i].expTxd));
      check($sformatf("vec%0d txBusy", i), 16'(txBusy), 16'(tbl[i].expBusy));
      check($sformatf("vec%0d fifoFull", i), 16'(fifoFull), 16'(tbl[i].expFull));
      check($sformatf("vec%0d overflow", i), 16'(overflow), 16'(tbl[i].expOvf));
    end

    // Single word A55A: high byte A5 then low byte 5A; busy drops after 2 frames.
    recvWord(0, "single", got);
    check("single word", got, 16'hA55A);
    check("single end txBusy", 16'(txBusy), 16'd0);
    check("single end txd", 16'(txd), 16'd1);

    // Six consecutive writes 1..6 while idle: word 1 is popped on the second edge,
    // the FIFO fills with 2..5 and word 6 is dropped.
    outputLineWrite = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      outputLine = 16'(i);
      tick();
      case (i)
        1: check("burst w1 txd", 16'(txd), 16'd1);
        2: check("burst w2 txd falls", 16'(txd), 16'd0);
        5: begin
          check("burst w5 fifoFull", 16'(fifoFull), 16'd1);
          check("burst w5 overflow", 16'(overflow), 16'd0);
        end
        6: begin
          check("burst w6 fifoFull", 16'(fifoFull), 16'd1);
          check("burst w6 overflow", 16'(overflow), 16'd1);
        end
        default: check("burst txBusy", 16'(txBusy), 16'd1);
      endcase
    end
    outputLineWrite = 1'b0;
    recvWord(4, "burst1", got);
    check("burst word 1", got, 16'd1);
    for (int n = 2; n <= 5; n++) begin
      check($sformatf("burst idle gap %0d", n), 16'(txd), 16'd1);
      tick();
      check($sformatf("burst fall %0d", n), 16'(txd), 16'd0);
      recvWord(0, $sformatf("burst%0d", n), got);
      check($sformatf("burst word %0d", n), got, 16'(n));
    end
    check("burst end txBusy", 16'(txBusy), 16'd0);
    check("burst end overflow sticky", 16'(overflow), 16'd1);
    check("burst end fifoFull", 16'(fifoFull), 16'd0);
    repeat (3) tick();
    check("burst idle txd", 16'(txd), 16'd1);

    // Reset during bit 3 of the first byte of 1234.
    outputLine = 16'h1234;
    outputLineWrite = 1'b1;
    tick();
    outputLineWrite = 1'b0;
    tick();
    check("abort fall", 16'(txd), 16'd0);
    repeat (18) tick();
    reset = 1'b1;
    tick();
    check("abort txd", 16'(txd), 16'd1);
    check("abort txBusy", 16'(txBusy), 16'd0);
    check("abort fifoFull", 16'(fifoFull), 16'd0);
    check("abort overflow", 16'(overflow), 16'd0);
    reset = 1'b0;
    tick();
    check("post-abort txd", 16'(txd), 16'd1);
    check("post-abort txBusy", 16'(txBusy), 16'd0);

    outputLine = 16'h00FF;
    outputLineWrite = 1'b1;
    tick();
    check("clean write txd", 16'(txd), 16'd1);
    check("clean write txBusy", 16'(txBusy), 16'd1);
    outputLineWrite = 1'b0;
    tick();
    check("clean fall", 16'(txd), 16'd0);
    recvWord(0, "clean", got);
    check("clean word", got, 16'h00FF);
    check("clean end txBusy", 16'(txBusy), 16'd0);

`ifdef IO_PARITY_EN
    // 03 has even weight (parity 0), 01 has odd weight (parity 1); word spans 88.
    outputLine = 16'h0301;
    outputLineWrite = 1'b1;
    tick();
    outputLineWrite = 1'b0;
    tick();
    check("parity fall", 16'(txd), 16'd0);
    recvWord(0, "parity", got);
    check("parity word", got, 16'h0301);
    check("parity end txBusy", 16'(txBusy), 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
